// File: rtl/pc_gen.sv
// Fetch-stage PC generator: PC register, redirect targets, exception/eret
// arbitration, stall-time redirect buffering and IF/ID flush pulse.
module pc_gen #(
  parameter int unsigned PC_W       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            exc_req,
  input  logic            eret,
  input  logic [PC_W-1:0] epc_in,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_kind,
  input  logic            br_taken,
  input  logic [15:0]     br_imm,
  input  logic [25:0]     j_addr,
  input  logic [PC_W-1:0] reg_in,
  input  logic [PC_W-1:0] base_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            flush,
  output logic            pc_misalign
);

  typedef enum logic [1:0] {
    K_NONE = 2'b00,
    K_BR   = 2'b01,
    K_J    = 2'b10,
    K_JR   = 2'b11
  } kind_e;

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VECTOR);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  logic            pend_vld_q, pend_vld_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [PC_W-1:0] b4;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] live_tgt;
  logic            live_hit;
  logic            eff_hit;
  logic [PC_W-1:0] eff_tgt;
  kind_e           kind;

  assign kind     = kind_e'(redirect_kind);
  assign b4       = base_pc + PC_W'(4);
  assign br_off   = {{(PC_W-18){br_imm[15]}}, br_imm, 2'b00};
  assign pc_plus4 = pc_q + PC_W'(4);

  always_comb begin
    live_hit = 1'b0;
    live_tgt = b4;
    unique case (kind)
      K_NONE: begin
        live_hit = 1'b0;
        live_tgt = b4;
      end
      K_BR: begin
        live_hit = redirect_valid & br_taken;
        live_tgt = b4 + br_off;
      end
      K_J: begin
        live_hit = redirect_valid;
        live_tgt = {b4[PC_W-1:28], j_addr, 2'b00};
      end
      K_JR: begin
        live_hit = redirect_valid;
        live_tgt = reg_in;
      end
    endcase
  end

  // A live redirect is younger than anything buffered, so it wins.
  assign eff_hit = live_hit | pend_vld_q;
  assign eff_tgt = live_hit ? live_tgt : pend_tgt_q;

  always_comb begin
    pc_d       = pc_q;
    flush_d    = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_req) begin
      pc_d       = EXC_PC;
      flush_d    = 1'b1;
      pend_vld_d = 1'b0;
    end else if (eret) begin
      pc_d       = epc_in;
      flush_d    = 1'b1;
      pend_vld_d = 1'b0;
    end else if (stall) begin
      if (live_hit) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = live_tgt;
      end
    end else if (eff_hit) begin
      pc_d       = eff_tgt;
      flush_d    = 1'b1;
      pend_vld_d = 1'b0;
    end else begin
      pc_d = pc_plus4;
    end
    mis_d = |pc_d[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RST_PC;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign pc_misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: 32-bit and 64-bit instances on a shared
// stimulus bus, each with its own expectation queue and monitor.
module tb_pc_gen;

  typedef struct {
    logic [63:0] pc;
    logic        fl;
    logic        mis;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        stall, exc_req, eret;
  logic [63:0] epc_in, reg_in, base_pc;
  logic        rv, br_taken;
  logic [1:0]  kind;
  logic [15:0] br_imm;
  logic [25:0] j_addr;

  logic [31:0] pc_a, p4_a;
  logic        fl_a, mis_a;
  logic [63:0] pc_b, p4_b;
  logic        fl_b, mis_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.PC_W(32)) dut_a (
    .clk(clk), .rst(rst_a), .stall(stall), .exc_req(exc_req),
    .eret(eret), .epc_in(epc_in[31:0]), .redirect_valid(rv),
    .redirect_kind(kind), .br_taken(br_taken), .br_imm(br_imm),
    .j_addr(j_addr), .reg_in(reg_in[31:0]),
    .base_pc(base_pc[31:0]), .pc(pc_a), .pc_plus4(p4_a),
    .flush(fl_a), .pc_misalign(mis_a)
  );

  pc_gen #(.PC_W(64)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall), .exc_req(exc_req),
    .eret(eret), .epc_in(epc_in), .redirect_valid(rv),
    .redirect_kind(kind), .br_taken(br_taken), .br_imm(br_imm),
    .j_addr(j_addr), .reg_in(reg_in), .base_pc(base_pc),
    .pc(pc_b), .pc_plus4(p4_b), .flush(fl_b), .pc_misalign(mis_b)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk({"A.pc ", e.nm}, {32'b0, pc_a}, e.pc);
      chk({"A.pc4 ", e.nm}, {32'b0, p4_a}, {32'b0, e.pc[31:0] + 32'd4});
      chk({"A.flush ", e.nm}, {63'b0, fl_a}, {63'b0, e.fl});
      chk({"A.mis ", e.nm}, {63'b0, mis_a}, {63'b0, e.mis});
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk({"B.pc ", e.nm}, pc_b, e.pc);
      chk({"B.pc4 ", e.nm}, p4_b, e.pc + 64'd4);
      chk({"B.flush ", e.nm}, {63'b0, fl_b}, {63'b0, e.fl});
      chk({"B.mis ", e.nm}, {63'b0, mis_b}, {63'b0, e.mis});
    end
  end

  task automatic clr();
    stall = 0; exc_req = 0; eret = 0; rv = 0; kind = 2'b00;
    br_taken = 0; br_imm = '0; j_addr = '0;
    epc_in = '0; reg_in = '0; base_pc = '0;
  endtask

  task automatic tick(input logic [63:0] p, input logic f,
                      input logic m, input string nm, input bit b);
    exp_t e;
    e.pc = p; e.fl = f; e.mis = m; e.nm = nm;
    if (b) qb.push_back(e);
    else qa.push_back(e);
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask

  task automatic jr(input logic [63:0] t);
    rv = 1; kind = 2'b11; reg_in = t;
  endtask

  task automatic jmp(input logic [63:0] b, input logic [25:0] a);
    rv = 1; kind = 2'b10; base_pc = b; j_addr = a;
  endtask

  task automatic br(input logic [63:0] b, input logic [15:0] i,
                    input logic t);
    rv = 1; kind = 2'b01; base_pc = b; br_imm = i; br_taken = t;
  endtask

  initial begin
    clr();
    rst_a = 1; rst_b = 1;
    tick(64'h3000, 0, 0, "reset0", 0);
    tick(64'h3000, 0, 0, "reset1", 0);
    rst_a = 0;
    tick(64'h3004, 0, 0, "seq1", 0);
    tick(64'h3008, 0, 0, "seq2", 0);
    tick(64'h300C, 0, 0, "seq3", 0);
    br(64'h3010, 16'hFFFE, 1);
    tick(64'h300C, 1, 0, "br_taken", 0);
    br(64'h3010, 16'hFFFE, 0);
    tick(64'h3010, 0, 0, "br_not_taken", 0);
    jmp(64'h3000, 26'h0000100);
    tick(64'h0400, 1, 0, "jump", 0);
    jr(64'h3042);
    tick(64'h3042, 1, 1, "jr_misalign", 0);
    tick(64'h3046, 0, 1, "seq_misalign", 0);
    jr(64'h3100);
    tick(64'h3100, 1, 0, "jr_align", 0);
    stall = 1; jmp(64'h3000, 26'h0000100);
    tick(64'h3100, 0, 0, "stall_j", 0);
    stall = 1; jr(64'h5000);
    tick(64'h3100, 0, 0, "stall_jr", 0);
    stall = 1;
    tick(64'h3100, 0, 0, "stall_idle", 0);
    tick(64'h5000, 1, 0, "pending_land", 0);
    tick(64'h5004, 0, 0, "after_pending", 0);
    stall = 1; jr(64'h6000);
    tick(64'h5004, 0, 0, "stall_pend2", 0);
    jr(64'h7000);
    tick(64'h7000, 1, 0, "live_beats_pend", 0);
    tick(64'h7004, 0, 0, "pend_dropped", 0);
    jr(64'h8000);
    tick(64'h8000, 1, 0, "b2b_1", 0);
    jr(64'h8010);
    tick(64'h8010, 1, 0, "b2b_2", 0);
    stall = 1; jr(64'h9000);
    tick(64'h8010, 0, 0, "stall_pend3", 0);
    stall = 1; exc_req = 1; br(64'h3010, 16'hFFFE, 1);
    tick(64'h4180, 1, 0, "exc_prio", 0);
    tick(64'h4184, 0, 0, "exc_cleared_pend", 0);
    eret = 1; epc_in = 64'h3020;
    tick(64'h3020, 1, 0, "eret", 0);
    exc_req = 1; eret = 1; epc_in = 64'h3020;
    tick(64'h4180, 1, 0, "exc_over_eret", 0);
    stall = 1; eret = 1; epc_in = 64'h3020;
    tick(64'h3020, 1, 0, "eret_stall", 0);
    stall = 1; jr(64'hA000);
    tick(64'h3020, 0, 0, "stall_pend4", 0);
    rst_a = 1; stall = 1;
    tick(64'h3000, 0, 0, "rst_drops_pend", 0);
    rst_a = 0;
    tick(64'h3004, 0, 0, "post_rst", 0);
    rv = 1; kind = 2'b00; reg_in = 64'hB000;
    tick(64'h3008, 0, 0, "kind00", 0);
    kind = 2'b11; reg_in = 64'hB000;
    tick(64'h300C, 0, 0, "valid_low", 0);

    rst_a = 1;
    tick(64'h3000, 0, 0, "b_reset", 1);
    rst_b = 0;
    jr(64'hFFFF_FFFF_FFFF_FFFC);
    tick(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, "b_top", 1);
    tick(64'h0, 0, 0, "b_wrap", 1);
    jmp(64'h1234_5678_9000_0000, 26'h0000100);
    tick(64'h1234_5678_9000_0400, 1, 0, "b_jump_hi", 1);
    br(64'h0, 16'hFFFE, 1);
    tick(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, "b_br_wrap", 1);

    repeat (3) @(posedge clk);
    #2;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               qa.size() + qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
